// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its round-robin picker.
package wb_arbiter_pkg;

    localparam int WORD_W    = 32;
    localparam int REGADDR_W = 5;
    localparam int REGTAG_W  = 4;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REGADDR_W-1:0] regaddr_t;
    typedef logic [REGTAG_W-1:0]  regtag_t;

    // Number of write-back / wake-up broadcast ports.
    localparam int WB_PORTS = 3;

    // Tag value meaning "no pending producer"; idle tag outputs carry it.
    localparam regtag_t UNLOCKED = '0;

endpackage

// File: rtl/wb_arbiter_pick.sv
// rr_pick3: combinational rotate-priority encoder. Scans the request vector
// circularly starting at ptr and returns up to three one-hot grants in scan
// order, their valid bits, and the pointer just past the last grant.
module rr_pick3
    import wb_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]                  req,
    input  logic [PTR_W-1:0]              ptr,
    output logic [WB_PORTS-1:0][N-1:0]    gnt,
    output logic [WB_PORTS-1:0]           gnt_valid,
    output logic [PTR_W-1:0]              next_ptr
);

    logic [PTR_W-1:0] idx;

    // Circular scan from ptr; the first three requesters fill slots 0, 1, 2.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt       = '0;
        gnt_valid = '0;
        next_ptr  = ptr;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                if (!gnt_valid[0]) begin
                    gnt[0][idx]  = 1'b1;
                    gnt_valid[0] = 1'b1;
                    next_ptr     = PTR_W'((int'(idx) + 1) % N);
                end else if (!gnt_valid[1]) begin
                    gnt[1][idx]  = 1'b1;
                    gnt_valid[1] = 1'b1;
                    next_ptr     = PTR_W'((int'(idx) + 1) % N);
                end else if (!gnt_valid[2]) begin
                    gnt[2][idx]  = 1'b1;
                    gnt_valid[2] = 1'b1;
                    next_ptr     = PTR_W'((int'(idx) + 1) % N);
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: collects results from NUM_SRC producers into one-entry holding
// buffers and broadcasts up to three per cycle, round-robin, on the write-back
// ports (which also drive reservation-station tag wake-up).
// Optional feature macro: WB_BYPASS_EN -- a firing source with an empty buffer
// competes in the same cycle, below all held entries.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = WORD_W,
    parameter int ADDR_W  = REGADDR_W,
    parameter int TAG_W   = REGTAG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        clr,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    output logic                        en_w0,
    output logic                        en_w1,
    output logic                        en_w2,
    output logic [ADDR_W-1:0]           reg_write_addr0,
    output logic [ADDR_W-1:0]           reg_write_addr1,
    output logic [ADDR_W-1:0]           reg_write_addr2,
    output logic [DATA_W-1:0]           write_data0,
    output logic [DATA_W-1:0]           write_data1,
    output logic [DATA_W-1:0]           write_data2,
    output logic [TAG_W-1:0]            write_tag0,
    output logic [TAG_W-1:0]            write_tag1,
    output logic [TAG_W-1:0]            write_tag2,
    output logic                        busy
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] hv, hv_nxt, fire, held_any, byp_take;
    logic [ADDR_W-1:0]  h_addr  [NUM_SRC];
    logic [DATA_W-1:0]  h_data  [NUM_SRC];
    logic [TAG_W-1:0]   h_tag   [NUM_SRC];
    logic [ADDR_W-1:0]  in_addr [NUM_SRC];
    logic [DATA_W-1:0]  in_data [NUM_SRC];
    logic [TAG_W-1:0]   in_tag  [NUM_SRC];

    logic [PTR_W-1:0]                   rr_ptr, ptr_nxt, held_next;
    logic [WB_PORTS-1:0][NUM_SRC-1:0]   held_gnt;
    logic [WB_PORTS-1:0]                held_vld, slot_vld;

    logic [ADDR_W-1:0]  slot_addr [WB_PORTS];
    logic [DATA_W-1:0]  slot_data [WB_PORTS];
    logic [TAG_W-1:0]   slot_tag  [WB_PORTS];

    logic [WB_PORTS-1:0] en_q;
    logic [ADDR_W-1:0]   addr_q [WB_PORTS];
    logic [DATA_W-1:0]   data_q [WB_PORTS];
    logic [TAG_W-1:0]    tag_q  [WB_PORTS];

    // Split the packed producer buses into per-source fields.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_addr[i] = src_addr[i*ADDR_W +: ADDR_W];
            in_data[i] = src_data[i*DATA_W +: DATA_W];
            in_tag[i]  = src_tag[i*TAG_W +: TAG_W];
        end
    end

    rr_pick3 #(.N(NUM_SRC), .PTR_W(PTR_W)) u_pick_held (
        .req       (hv),
        .ptr       (rr_ptr),
        .gnt       (held_gnt),
        .gnt_valid (held_vld),
        .next_ptr  (held_next)
    );

    // Sources whose held entry drains this cycle, whichever slot took them.
    always_comb begin
        held_any = '0;
        for (int k = 0; k < WB_PORTS; k++) held_any = held_any | held_gnt[k];
    end

    // A buffer accepts when empty or when its entry is leaving this cycle.
    assign src_ready = {NUM_SRC{rdy & ~clr}} & (~hv | held_any);
    assign fire      = src_valid & src_ready;

`ifdef WB_BYPASS_EN
    logic [NUM_SRC-1:0]                 byp_req;
    logic [WB_PORTS-1:0][NUM_SRC-1:0]   byp_gnt, slot_byp;
    logic [WB_PORTS-1:0]                byp_vld, slot_bv;
    logic [PTR_W-1:0]                   byp_next;

    // Pointer value just past the single set bit of a one-hot source vector.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [NUM_SRC-1:0] oh);
        logic [PTR_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (oh[i]) p = PTR_W'((i + 1) % NUM_SRC);
        return p;
    endfunction

    // Only empty buffers can bypass; a refill behind a draining entry is captured.
    assign byp_req = fire & ~hv;

    rr_pick3 #(.N(NUM_SRC), .PTR_W(PTR_W)) u_pick_byp (
        .req       (byp_req),
        .ptr       (rr_ptr),
        .gnt       (byp_gnt),
        .gnt_valid (byp_vld),
        .next_ptr  (byp_next)
    );

    // Bypass candidates take whichever slots the held entries left free.
    always_comb begin
        slot_byp = '0;
        slot_bv  = '0;
        ptr_nxt  = held_next;
        case (held_vld)
            3'b000: begin
                slot_byp = byp_gnt;
                slot_bv  = byp_vld;
                ptr_nxt  = byp_next;
            end
            3'b001: begin
                slot_byp[1] = byp_gnt[0];
                slot_byp[2] = byp_gnt[1];
                slot_bv     = {byp_vld[1], byp_vld[0], 1'b0};
                if (byp_vld[1])      ptr_nxt = ptr_after(byp_gnt[1]);
                else if (byp_vld[0]) ptr_nxt = ptr_after(byp_gnt[0]);
            end
            3'b011: begin
                slot_byp[2] = byp_gnt[0];
                slot_bv     = {byp_vld[0], 2'b00};
                if (byp_vld[0]) ptr_nxt = ptr_after(byp_gnt[0]);
            end
            default: ;
        endcase
        slot_vld = held_vld | slot_bv;
        byp_take = '0;
        for (int k = 0; k < WB_PORTS; k++) byp_take = byp_take | slot_byp[k];
    end
`else
    // Only held entries compete.
    always_comb begin
        slot_vld = held_vld;
        ptr_nxt  = held_next;
        byp_take = '0;
    end
`endif

    // Slot payload mux; grants are one-hot per slot so an OR-reduce suffices.
    always_comb begin
        for (int k = 0; k < WB_PORTS; k++) begin
            slot_addr[k] = '0;
            slot_data[k] = '0;
            slot_tag[k]  = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (held_gnt[k][i]) begin
                    slot_addr[k] = slot_addr[k] | h_addr[i];
                    slot_data[k] = slot_data[k] | h_data[i];
                    slot_tag[k]  = slot_tag[k]  | h_tag[i];
                end
`ifdef WB_BYPASS_EN
                if (slot_byp[k][i]) begin
                    slot_addr[k] = slot_addr[k] | in_addr[i];
                    slot_data[k] = slot_data[k] | in_data[i];
                    slot_tag[k]  = slot_tag[k]  | in_tag[i];
                end
`endif
            end
        end
    end

    // Next occupancy: drained entries leave, non-bypassed fires arrive, flush empties all.
    always_comb begin
        hv_nxt = clr ? '0 : ((hv & ~held_any) | (fire & ~byp_take));
    end

    // Holding-entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (rst)      hv <= '0;
        else if (rdy) hv <= hv_nxt;
    end

    // Holding-entry payload, written on every accepted fire.
    always_ff @(posedge clk) begin
        // NOTE: payload needs no reset; it is only ever read behind a set hv bit.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fire[i]) begin
                h_addr[i] <= in_addr[i];
                h_data[i] <= in_data[i];
                h_tag[i]  <= in_tag[i];
            end
        end
    end

    // Round-robin pointer; a flush keeps it so fairness survives mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               rr_ptr <= '0;
        else if (rdy && !clr)  rr_ptr <= ptr_nxt;
    end

    // Registered write-back slots and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
            busy <= 1'b0;
            for (int k = 0; k < WB_PORTS; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
                tag_q[k]  <= TAG_W'(UNLOCKED);
            end
        end else if (rdy) begin
            en_q <= clr ? '0 : slot_vld;
            busy <= |hv_nxt;
            for (int k = 0; k < WB_PORTS; k++) begin
                addr_q[k] <= slot_addr[k];
                data_q[k] <= slot_data[k];
                tag_q[k]  <= slot_tag[k];
            end
        end
    end

    assign en_w0           = en_q[0];
    assign en_w1           = en_q[1];
    assign en_w2           = en_q[2];
    assign reg_write_addr0 = addr_q[0];
    assign reg_write_addr1 = addr_q[1];
    assign reg_write_addr2 = addr_q[2];
    assign write_data0     = data_q[0];
    assign write_data1     = data_q[1];
    assign write_data2     = data_q[2];
    assign write_tag0      = tag_q[0];
    assign write_tag1      = tag_q[1];
    assign write_tag2      = tag_q[2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter (NUM_SRC=4): directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TW = 4;
`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            rst, rdy, clr;
    logic [N-1:0]    src_valid, src_ready;
    logic [N*AW-1:0] src_addr;
    logic [N*DW-1:0] src_data;
    logic [N*TW-1:0] src_tag;
    logic            en_w0, en_w1, en_w2, busy;
    logic [AW-1:0]   reg_write_addr0, reg_write_addr1, reg_write_addr2;
    logic [DW-1:0]   write_data0, write_data1, write_data2;
    logic [TW-1:0]   write_tag0, write_tag1, write_tag2;

    logic [AW-1:0] v_addr [N];
    logic [DW-1:0] v_data [N];
    logic [TW-1:0] v_tag  [N];

    // reference model state
    bit            m_hv   [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    logic [TW-1:0] m_tag  [N];
    int            m_ptr;
    bit            exp_en   [3];
    logic [AW-1:0] exp_addr [3];
    logic [DW-1:0] exp_data [3];
    logic [TW-1:0] exp_tag  [3];
    bit            exp_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_addr[i*AW +: AW] = v_addr[i];
            src_data[i*DW +: DW] = v_data[i];
            src_tag[i*TW +: TW]  = v_tag[i];
        end
    end

    wb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data), .src_tag(src_tag),
        .en_w0(en_w0), .en_w1(en_w1), .en_w2(en_w2),
        .reg_write_addr0(reg_write_addr0), .reg_write_addr1(reg_write_addr1),
        .reg_write_addr2(reg_write_addr2),
        .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
        .write_tag0(write_tag0), .write_tag1(write_tag1), .write_tag2(write_tag2),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic out_en(int s);
        case (s) 0: return en_w0; 1: return en_w1; default: return en_w2; endcase
    endfunction
    function automatic logic [AW-1:0] out_addr(int s);
        case (s) 0: return reg_write_addr0; 1: return reg_write_addr1; default: return reg_write_addr2; endcase
    endfunction
    function automatic logic [DW-1:0] out_data(int s);
        case (s) 0: return write_data0; 1: return write_data1; default: return write_data2; endcase
    endfunction
    function automatic logic [TW-1:0] out_tag(int s);
        case (s) 0: return write_tag0; 1: return write_tag1; default: return write_tag2; endcase
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        exp_busy = 0;
        for (int i = 0; i < N; i++) m_hv[i] = 0;
        for (int s = 0; s < 3; s++) begin
            exp_en[s] = 0; exp_addr[s] = '0; exp_data[s] = '0; exp_tag[s] = '0;
        end
    endtask

    // Set valids and fresh random payloads (caller may override fields afterwards).
    task automatic drive(input logic [N-1:0] v);
        src_valid = v;
        for (int i = 0; i < N; i++) begin
            v_addr[i] = AW'($urandom);
            v_data[i] = $urandom;
            v_tag[i]  = TW'($urandom);
        end
    endtask

    // Called at a negedge after inputs are driven: checks src_ready, advances the
    // model across the next posedge and checks the registered outputs.
    task automatic cycle();
        bit   g_held [N];
        bit   g_byp  [N];
        int   sel [$];
        bit   sel_b [$];
        logic [N-1:0] er;
        int   src;
        #1;
        for (int k = 0; k < N; k++) begin g_held[k] = 0; g_byp[k] = 0; end
        for (int k = 0; k < N; k++) begin
            src = (m_ptr + k) % N;
            if (m_hv[src] && sel.size() < 3) begin
                sel.push_back(src); sel_b.push_back(1'b0); g_held[src] = 1;
            end
        end
`ifdef WB_BYPASS_EN
        for (int k = 0; k < N; k++) begin
            src = (m_ptr + k) % N;
            if (rdy && !clr && src_valid[src] && !m_hv[src] && sel.size() < 3) begin
                sel.push_back(src); sel_b.push_back(1'b1); g_byp[src] = 1;
            end
        end
`endif
        for (int k = 0; k < N; k++) er[k] = rdy && !clr && (!m_hv[k] || g_held[k]);
        check("src_ready", src_ready, er);
        if (rdy) begin
            if (clr) begin
                for (int k = 0; k < N; k++) m_hv[k] = 0;
                for (int s = 0; s < 3; s++) exp_en[s] = 0;
                exp_busy = 0;
            end else begin
                for (int s = 0; s < 3; s++) begin
                    exp_en[s] = (s < sel.size());
                    if (exp_en[s]) begin
                        src = sel[s];
                        exp_addr[s] = sel_b[s] ? v_addr[src] : m_addr[src];
                        exp_data[s] = sel_b[s] ? v_data[src] : m_data[src];
                        exp_tag[s]  = sel_b[s] ? v_tag[src]  : m_tag[src];
                    end
                end
                if (sel.size() > 0) m_ptr = (sel[sel.size()-1] + 1) % N;
                for (int k = 0; k < N; k++) begin
                    if (g_held[k]) m_hv[k] = 0;
                    if (src_valid[k] && er[k] && !g_byp[k]) begin
                        m_hv[k] = 1; m_addr[k] = v_addr[k]; m_data[k] = v_data[k]; m_tag[k] = v_tag[k];
                    end
                end
                exp_busy = 0;
                for (int k = 0; k < N; k++) if (m_hv[k]) exp_busy = 1;
            end
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("en_w%0d", s), out_en(s), exp_en[s]);
            if (exp_en[s]) begin
                check($sformatf("addr%0d", s), out_addr(s), exp_addr[s]);
                check($sformatf("data%0d", s), out_data(s), exp_data[s]);
                check($sformatf("tag%0d", s),  out_tag(s),  exp_tag[s]);
            end
        end
        check("busy", busy, exp_busy);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s_en%0d", tag, s),   out_en(s),   1'b0);
            check($sformatf("%s_addr%0d", tag, s), out_addr(s), '0);
            check($sformatf("%s_data%0d", tag, s), out_data(s), '0);
            check($sformatf("%s_tag%0d", tag, s),  out_tag(s),  '0);
        end
        check($sformatf("%s_busy", tag), busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        drive('0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst0");
        check("rst0_ready", src_ready, 4'hF);
        @(negedge clk);

        // contention: all four fire together, pointer starts at 0
        drive(4'hF);
        for (int i = 0; i < N; i++) begin
            v_addr[i] = AW'(i + 1); v_data[i] = 32'(100 + i); v_tag[i] = TW'(8 + i);
        end
        for (int c = 1; c <= 3; c++) begin
            cycle();
            if (c == LAT) begin
                check("cont_en", {en_w2, en_w1, en_w0}, 3'b111);
                check("cont_d0", write_data0, 100);
                check("cont_d1", write_data1, 101);
                check("cont_d2", write_data2, 102);
            end
            if (c == LAT + 1) begin
                check("cont2_en", {en_w2, en_w1, en_w0}, 3'b001);
                check("cont2_d0", write_data0, 103);
            end
            drive('0);
        end
        cycle();

        // asynchronous reset in the middle of a cycle with three entries in flight
        drive(4'b1011);
        cycle();
        drive('0);
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // single result latency on src2
        drive(4'b0100);
        v_addr[2] = 5'd7; v_data[2] = 32'hDEAD; v_tag[2] = 4'd3;
        for (int c = 1; c <= 3; c++) begin
            cycle();
            if (c == LAT) begin
                check("lat_en0", en_w0, 1'b1);
                check("lat_addr0", reg_write_addr0, 5'd7);
                check("lat_data0", write_data0, 32'hDEAD);
                check("lat_tag0", write_tag0, 4'd3);
            end
            drive('0);
        end

        // back-to-back results from src1
        for (int j = 0; j < 8; j++) begin
            drive(4'b0010);
            v_data[1] = 32'(j);
            cycle();
        end
        drive('0);
        repeat (3) cycle();

        // flush: hold src0/src3, then clr while src1 tries to fire
        drive(4'b1001);
        cycle();
        drive(4'b0010);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        drive('0);
        repeat (2) cycle();

        // rdy low freezes everything for 5 cycles, then the pending grant emits once
        drive(4'b0111);
        cycle();
        drive(4'b1000);
        cycle();
        rdy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            drive(4'(($urandom)));
            cycle();
        end
        rdy = 1'b1;
        drive('0);
        repeat (3) cycle();

        // repeated full load, then idle single fire on src0
        repeat (2) begin drive(4'hF); cycle(); end
        drive('0);
        repeat (3) cycle();
        drive(4'b0001);
        cycle();
        drive('0);
        repeat (2) cycle();

        // random traffic
        for (int j = 0; j < 400; j++) begin
            rdy = (($urandom % 8) != 0);
            clr = (($urandom % 25) == 0);
            drive(4'($urandom));
            cycle();
        end
        rdy = 1'b1; clr = 1'b0;
        drive('0);
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
